skewed_weight_fifo: RTL

SKEWED_WEIGHT_FIFO -- requirements
Module: skewed_weight_fifo

---
 rtl/skewed_weight_fifo.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/skewed_weight_fifo.sv
// Row FIFO feeding a systolic array: stores rows of LANES signed weights and
// presents each popped row either aligned or diagonally skewed (lane i
// delayed by i cycles).
module skewed_weight_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [LANES*DATA_WIDTH-1:0]   push_data,
  input  logic                          pop,
  input  logic                          skew_en,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [LANES*DATA_WIDTH-1:0]   lane_data,
  output logic [LANES-1:0]              lane_valid,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned RowW = LANES * DATA_WIDTH;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t PtrLast = ptr_t'(DEPTH - 1);

  logic [RowW-1:0] mem_q [DEPTH];
  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, underflow_q;
  logic            push_ok, pop_ok;
  logic            skew_load, align_load;
  logic [RowW-1:0] rd_row;

  // Status comes only from registered count, never from push/pop.
  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign skew_load  = pop_ok & skew_en;
  assign align_load = pop_ok & ~skew_en;
  assign rd_row     = mem_q[rd_ptr_q];

  // Next-state for pointers (explicit wrap for any DEPTH) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + ptr_t'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + ptr_t'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Row storage; deliberately not reset, rows are unreadable until written.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && full) overflow_q <= 1'b1;
      if (pop && empty) underflow_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] row_lane;
    logic                  in_v;
    logic [DATA_WIDTH-1:0] in_d;
    logic                  v_q;
    logic [DATA_WIDTH-1:0] d_q;

    assign row_lane = rd_row[i*DATA_WIDTH +: DATA_WIDTH];

    if (i == 0) begin : g_direct
      // Lane 0 has zero skew, so both modes load it straight from the pop.
      assign in_v = pop_ok;
      assign in_d = row_lane;
    end else begin : g_chain
      logic [i-1:0]          sv_q;
      logic [DATA_WIDTH-1:0] sd_q [i];

      // i-stage delay chain; data stages only move when their valid moves.
      always_ff @(posedge clk) begin
        if (reset) begin
          sv_q <= '0;
          for (int k = 0; k < i; k++) sd_q[k] <= '0;
        end else begin
          sv_q[0] <= skew_load;
          if (skew_load) sd_q[0] <= row_lane;
          for (int k = 1; k < i; k++) begin
            sv_q[k] <= sv_q[k-1];
            if (sv_q[k-1]) sd_q[k] <= sd_q[k-1];
          end
        end
      end

      // An older skewed weight wins over an aligned row landing the same cycle.
      assign in_v = sv_q[i-1] | align_load;
      assign in_d = sv_q[i-1] ? sd_q[i-1] : row_lane;
    end

    // Output register; data holds when no fresh weight arrives.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= in_v;
        if (in_v) d_q <= in_d;
      end
    end

    assign lane_valid[i]                           = v_q;
    assign lane_data[i*DATA_WIDTH +: DATA_WIDTH]   = d_q;
  end

endmodule
